// File: rtl/fifo_rr_scheduler_if.sv
// Bundle of the request, FIFO-side and status signals for fifo_rr_scheduler.
// The requester/testbench side uses master; the scheduler uses slave.
interface fifo_rr_scheduler_if #(
  parameter int DATA_WIDTH    = 65,
  parameter int ADDRESS_WIDTH = 2
);
  logic                      stall;
  logic [3:0]                Req_in;
  logic [4*DATA_WIDTH-1:0]   Data_in;
  logic                      Pop_in;
  logic                      Flush_in;
  logic [3:0]                Grant_out;
  logic [DATA_WIDTH-1:0]     Fifo_Data_out;
  logic                      Fifo_WriteEn_out;
  logic                      Fifo_Clear_out;
  logic [ADDRESS_WIDTH:0]    Count_out;
  logic                      Busy_out;

  modport master (
    output stall, Req_in, Data_in, Pop_in, Flush_in,
    input  Grant_out, Fifo_Data_out, Fifo_WriteEn_out, Fifo_Clear_out, Count_out, Busy_out
  );

  modport slave (
    input  stall, Req_in, Data_in, Pop_in, Flush_in,
    output Grant_out, Fifo_Data_out, Fifo_WriteEn_out, Fifo_Clear_out, Count_out, Busy_out
  );
endinterface

// File: rtl/fifo_rr_scheduler.sv
// Four-requester round-robin writer into a FIFO, with registered grant/write
// outputs, occupancy tracking, and a two-cycle FIFO clear after reset or flush.
module fifo_rr_scheduler #(
  parameter int DATA_WIDTH    = 65,
  parameter int ADDRESS_WIDTH = 2
) (
  input logic               Clk,
  input logic               Clear_in,
  fifo_rr_scheduler_if.slave bus
);

  localparam logic [ADDRESS_WIDTH:0] CAP = (ADDRESS_WIDTH+1)'((1 << ADDRESS_WIDTH) - 1);
  localparam logic [ADDRESS_WIDTH:0] ONE = (ADDRESS_WIDTH+1)'(1);

  typedef enum logic [1:0] {INIT, ARB, FLUSH} state_t;

  state_t                  state_q, state_d;
  logic                    phase_q, phase_d;
  logic                    clear_q, clear_d;
  logic [3:0]              grant_q, grant_d;
  logic                    we_q, we_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [ADDRESS_WIDTH:0]  count_q, count_d;
  logic [1:0]              last_q, last_d;

  logic                    win_valid;
  logic [1:0]              win_idx;
  logic [1:0]              cand;
  logic                    can_grant;
  logic                    pop_eff;

  // Search begins one past the last winner so every requester gets a turn.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = 2'd0;
    cand      = 2'd0;
    for (int i = 1; i <= 4; i++) begin
      cand = last_q + 2'(i);
      if (!win_valid && bus.Req_in[cand]) begin
        win_valid = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign can_grant = (state_q == ARB) && !bus.stall && !bus.Flush_in &&
                     win_valid && (count_q < CAP);
  assign pop_eff   = bus.Pop_in && (count_q != '0);

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    clear_d = 1'b0;
    grant_d = 4'b0000;
    we_d    = 1'b0;
    data_d  = data_q;
    count_d = count_q;
    last_d  = last_q;
    unique case (state_q)
      INIT, FLUSH: begin
        // phase_q counts the two clear cycles; pops and flush requests are ignored.
        if (state_q == FLUSH) count_d = '0;
        if (phase_q) begin
          state_d = ARB;
          phase_d = 1'b0;
        end else begin
          phase_d = 1'b1;
          clear_d = 1'b1;
        end
      end
      ARB: begin
        if (bus.Flush_in) begin
          state_d = FLUSH;
          phase_d = 1'b0;
          clear_d = 1'b1;
          count_d = '0;
        end else begin
          if (can_grant) begin
            grant_d = 4'b0001 << win_idx;
            we_d    = 1'b1;
            data_d  = bus.Data_in[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
            last_d  = win_idx;
          end
          unique case ({can_grant, pop_eff})
            2'b10:   count_d = count_q + ONE;
            2'b01:   count_d = count_q - ONE;
            default: count_d = count_q;
          endcase
        end
      end
      default: begin
        state_d = INIT;
        phase_d = 1'b0;
        clear_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Clear_in) begin
    if (Clear_in) begin
      state_q <= INIT;
      phase_q <= 1'b0;
      clear_q <= 1'b1;
      grant_q <= 4'b0000;
      we_q    <= 1'b0;
      data_q  <= '0;
      count_q <= '0;
      last_q  <= 2'd3;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      clear_q <= clear_d;
      grant_q <= grant_d;
      we_q    <= we_d;
      data_q  <= data_d;
      count_q <= count_d;
      last_q  <= last_d;
    end
  end

  assign bus.Grant_out        = grant_q;
  assign bus.Fifo_WriteEn_out = we_q;
  assign bus.Fifo_Data_out    = data_q;
  assign bus.Fifo_Clear_out   = clear_q;
  assign bus.Count_out        = count_q;
  assign bus.Busy_out         = (state_q != ARB);

endmodule

// File: tb/tb_fifo_rr_scheduler.sv
// Self-checking bench for fifo_rr_scheduler: expected writes are queued as
// stimulus is applied and popped when the scheduler issues a FIFO write.
module tb_fifo_rr_scheduler;

  localparam int DW = 65;
  localparam int AW = 2;

  typedef struct {
    logic [3:0]    grant;
    logic [DW-1:0] data;
  } exp_t;

  logic Clk = 1'b0;
  logic Clear_in;
  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];
  logic [DW-1:0] word [4];

  always #5 Clk = ~Clk;

  fifo_rr_scheduler_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus ();

  fifo_rr_scheduler #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
    .Clk      (Clk),
    .Clear_in (Clear_in),
    .bus      (bus)
  );

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic load_words();
    for (int i = 0; i < 4; i++) begin
      word[i] = {1'(i), 32'($urandom), 32'($urandom)};
      bus.Data_in[i*DW +: DW] = word[i];
    end
  endtask

  task automatic push_exp(input int idx);
    exp_t e;
    e.grant = 4'b0001 << idx;
    e.data  = word[idx];
    sb.push_back(e);
  endtask

  task automatic do_reset();
    Clear_in     = 1'b1;
    bus.stall    = 1'b0;
    bus.Req_in   = 4'b0000;
    bus.Pop_in   = 1'b0;
    bus.Flush_in = 1'b0;
    step();
    step();
    Clear_in = 1'b0;
    step();
    step();
  endtask

  task automatic test_reset();
    exp_t e;
    Clear_in     = 1'b1;
    bus.stall    = 1'b0;
    bus.Pop_in   = 1'b0;
    bus.Flush_in = 1'b0;
    bus.Req_in   = 4'b0001;
    load_words();
    step();
    step();
    checks++; if (bus.Fifo_Clear_out !== 1'b1) begin failures++; $display("[TB] FAIL reset_clear got=%b exp=1", bus.Fifo_Clear_out); end
    checks++; if (bus.Grant_out !== 4'b0000) begin failures++; $display("[TB] FAIL reset_grant got=%b exp=0000", bus.Grant_out); end
    checks++; if (bus.Fifo_WriteEn_out !== 1'b0) begin failures++; $display("[TB] FAIL reset_we got=%b exp=0", bus.Fifo_WriteEn_out); end
    checks++; if (bus.Fifo_Data_out !== '0) begin failures++; $display("[TB] FAIL reset_data got=%h exp=0", bus.Fifo_Data_out); end
    checks++; if (bus.Count_out !== 3'd0) begin failures++; $display("[TB] FAIL reset_count got=%0d exp=0", bus.Count_out); end
    checks++; if (bus.Busy_out !== 1'b1) begin failures++; $display("[TB] FAIL reset_busy got=%b exp=1", bus.Busy_out); end
    Clear_in = 1'b0;
    step();
    checks++; if (bus.Fifo_Clear_out !== 1'b1) begin failures++; $display("[TB] FAIL init_clear1 got=%b exp=1", bus.Fifo_Clear_out); end
    checks++; if (bus.Busy_out !== 1'b1) begin failures++; $display("[TB] FAIL init_busy1 got=%b exp=1", bus.Busy_out); end
    step();
    checks++; if (bus.Fifo_Clear_out !== 1'b0) begin failures++; $display("[TB] FAIL init_clear2 got=%b exp=0", bus.Fifo_Clear_out); end
    checks++; if (bus.Busy_out !== 1'b0) begin failures++; $display("[TB] FAIL init_busy2 got=%b exp=0", bus.Busy_out); end
    checks++; if (bus.Fifo_WriteEn_out !== 1'b0) begin failures++; $display("[TB] FAIL init_we got=%b exp=0", bus.Fifo_WriteEn_out); end
    push_exp(0);
    step();
    checks++;
    if (bus.Fifo_WriteEn_out !== 1'b1) begin failures++; $display("[TB] FAIL first_we got=%b exp=1", bus.Fifo_WriteEn_out); end
    else begin
      e = sb.pop_front();
      checks++; if (bus.Grant_out !== e.grant) begin failures++; $display("[TB] FAIL first_grant got=%b exp=%b", bus.Grant_out, e.grant); end
      checks++; if (bus.Fifo_Data_out !== e.data) begin failures++; $display("[TB] FAIL first_data got=%h exp=%h", bus.Fifo_Data_out, e.data); end
    end
    checks++; if (bus.Count_out !== 3'd1) begin failures++; $display("[TB] FAIL first_count got=%0d exp=1", bus.Count_out); end
    bus.Req_in = 4'b0000;
    step();
    checks++; if (bus.Fifo_WriteEn_out !== 1'b0) begin failures++; $display("[TB] FAIL idle_we got=%b exp=0", bus.Fifo_WriteEn_out); end
    checks++; if (bus.Fifo_Data_out !== word[0]) begin failures++; $display("[TB] FAIL idle_data_hold got=%h exp=%h", bus.Fifo_Data_out, word[0]); end
  endtask

  task automatic test_round_robin();
    int   idx_seq [5] = '{0, 1, 2, 3, 0};
    exp_t e;
    do_reset();
    load_words();
    bus.Req_in = 4'b1111;
    bus.Pop_in = 1'b1;
    for (int k = 0; k < 5; k++) begin
      push_exp(idx_seq[k]);
      step();
      checks++;
      if (bus.Fifo_WriteEn_out !== 1'b1) begin failures++; $display("[TB] FAIL rr_we[%0d] got=%b exp=1", k, bus.Fifo_WriteEn_out); end
      else begin
        e = sb.pop_front();
        checks++; if (bus.Grant_out !== e.grant) begin failures++; $display("[TB] FAIL rr_grant[%0d] got=%b exp=%b", k, bus.Grant_out, e.grant); end
        checks++; if (bus.Fifo_Data_out !== e.data) begin failures++; $display("[TB] FAIL rr_data[%0d] got=%h exp=%h", k, bus.Fifo_Data_out, e.data); end
      end
      checks++; if (bus.Count_out !== 3'd1) begin failures++; $display("[TB] FAIL rr_count[%0d] got=%0d exp=1", k, bus.Count_out); end
    end
    bus.Req_in = 4'b0000;
    bus.Pop_in = 1'b0;
    step();
    checks++; if (bus.Grant_out !== 4'b0000) begin failures++; $display("[TB] FAIL rr_idle_grant got=%b exp=0000", bus.Grant_out); end
  endtask

  task automatic test_full();
    exp_t e;
    do_reset();
    load_words();
    bus.Req_in = 4'b0100;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) begin
        bus.Pop_in = 1'b1;
        step();
        bus.Pop_in = 1'b0;
        checks++; if (bus.Fifo_WriteEn_out !== 1'b0) begin failures++; $display("[TB] FAIL full_pop_we got=%b exp=0", bus.Fifo_WriteEn_out); end
        checks++; if (bus.Count_out !== 3'd2) begin failures++; $display("[TB] FAIL full_pop_count got=%0d exp=2", bus.Count_out); end
      end
      push_exp(2);
      step();
      checks++;
      if (bus.Fifo_WriteEn_out !== 1'b1) begin failures++; $display("[TB] FAIL full_we[%0d] got=%b exp=1", k, bus.Fifo_WriteEn_out); end
      else begin
        e = sb.pop_front();
        checks++; if (bus.Grant_out !== e.grant) begin failures++; $display("[TB] FAIL full_grant[%0d] got=%b exp=%b", k, bus.Grant_out, e.grant); end
      end
      checks++; if (bus.Count_out !== 3'((k < 3) ? k + 1 : 3)) begin failures++; $display("[TB] FAIL full_count[%0d] got=%0d", k, bus.Count_out); end
      if (k == 2) begin
        for (int j = 0; j < 2; j++) begin
          step();
          checks++; if (bus.Fifo_WriteEn_out !== 1'b0) begin failures++; $display("[TB] FAIL full_block_we[%0d] got=%b exp=0", j, bus.Fifo_WriteEn_out); end
          checks++; if (bus.Count_out !== 3'd3) begin failures++; $display("[TB] FAIL full_block_count[%0d] got=%0d exp=3", j, bus.Count_out); end
        end
      end
    end
    step();
    checks++; if (bus.Fifo_WriteEn_out !== 1'b0) begin failures++; $display("[TB] FAIL full_after_we got=%b exp=0", bus.Fifo_WriteEn_out); end
  endtask

  task automatic test_flush();
    exp_t e;
    bus.Req_in   = 4'b0011;
    bus.Flush_in = 1'b1;
    step();
    checks++; if (bus.Fifo_WriteEn_out !== 1'b0) begin failures++; $display("[TB] FAIL flush_we got=%b exp=0", bus.Fifo_WriteEn_out); end
    checks++; if (bus.Fifo_Clear_out !== 1'b1) begin failures++; $display("[TB] FAIL flush_clear1 got=%b exp=1", bus.Fifo_Clear_out); end
    checks++; if (bus.Count_out !== 3'd0) begin failures++; $display("[TB] FAIL flush_count got=%0d exp=0", bus.Count_out); end
    checks++; if (bus.Busy_out !== 1'b1) begin failures++; $display("[TB] FAIL flush_busy got=%b exp=1", bus.Busy_out); end
    step();
    bus.Flush_in = 1'b0;
    checks++; if (bus.Fifo_Clear_out !== 1'b1) begin failures++; $display("[TB] FAIL flush_clear2 got=%b exp=1", bus.Fifo_Clear_out); end
    checks++; if (bus.Grant_out !== 4'b0000) begin failures++; $display("[TB] FAIL flush_grant got=%b exp=0000", bus.Grant_out); end
    step();
    checks++; if (bus.Fifo_Clear_out !== 1'b0) begin failures++; $display("[TB] FAIL flush_clear3 got=%b exp=0", bus.Fifo_Clear_out); end
    checks++; if (bus.Busy_out !== 1'b0) begin failures++; $display("[TB] FAIL flush_done_busy got=%b exp=0", bus.Busy_out); end
    push_exp(0);
    step();
    checks++;
    if (bus.Fifo_WriteEn_out !== 1'b1) begin failures++; $display("[TB] FAIL post_flush_we got=%b exp=1", bus.Fifo_WriteEn_out); end
    else begin
      e = sb.pop_front();
      checks++; if (bus.Grant_out !== e.grant) begin failures++; $display("[TB] FAIL post_flush_grant got=%b exp=%b", bus.Grant_out, e.grant); end
    end
    checks++; if (bus.Count_out !== 3'd1) begin failures++; $display("[TB] FAIL post_flush_count got=%0d exp=1", bus.Count_out); end
    bus.Flush_in = 1'b1;
    step();
    bus.Flush_in = 1'b0;
    bus.Req_in   = 4'b0000;
    checks++; if (bus.Fifo_WriteEn_out !== 1'b0) begin failures++; $display("[TB] FAIL flush_wins_we got=%b exp=0", bus.Fifo_WriteEn_out); end
    checks++; if (bus.Count_out !== 3'd0) begin failures++; $display("[TB] FAIL flush_wins_count got=%0d exp=0", bus.Count_out); end
    step();
    step();
    checks++; if (bus.Busy_out !== 1'b0) begin failures++; $display("[TB] FAIL flush_wins_busy got=%b exp=0", bus.Busy_out); end
  endtask

  task automatic test_stall();
    exp_t e;
    do_reset();
    load_words();
    bus.Req_in = 4'b1000;
    bus.stall  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++; if (bus.Fifo_WriteEn_out !== 1'b0) begin failures++; $display("[TB] FAIL stall_we[%0d] got=%b exp=0", k, bus.Fifo_WriteEn_out); end
    end
    bus.stall = 1'b0;
    push_exp(3);
    step();
    checks++;
    if (bus.Fifo_WriteEn_out !== 1'b1) begin failures++; $display("[TB] FAIL unstall_we got=%b exp=1", bus.Fifo_WriteEn_out); end
    else begin
      e = sb.pop_front();
      checks++; if (bus.Grant_out !== e.grant) begin failures++; $display("[TB] FAIL unstall_grant got=%b exp=%b", bus.Grant_out, e.grant); end
      checks++; if (bus.Fifo_Data_out !== e.data) begin failures++; $display("[TB] FAIL unstall_data got=%h exp=%h", bus.Fifo_Data_out, e.data); end
    end
    bus.Req_in = 4'b0000;
    bus.stall  = 1'b1;
    bus.Pop_in = 1'b1;
    step();
    checks++; if (bus.Count_out !== 3'd0) begin failures++; $display("[TB] FAIL stall_pop_count got=%0d exp=0", bus.Count_out); end
    step();
    checks++; if (bus.Count_out !== 3'd0) begin failures++; $display("[TB] FAIL underflow_count got=%0d exp=0", bus.Count_out); end
    bus.Pop_in = 1'b0;
    bus.stall  = 1'b0;
  endtask

  task automatic test_async_clear();
    exp_t e;
    do_reset();
    load_words();
    bus.Req_in = 4'b0001;
    push_exp(0);
    step();
    checks++;
    if (bus.Fifo_WriteEn_out !== 1'b1) begin failures++; $display("[TB] FAIL aclr_pre_we got=%b exp=1", bus.Fifo_WriteEn_out); end
    else e = sb.pop_front();
    #2 Clear_in = 1'b1;
    #1;
    checks++; if (bus.Fifo_WriteEn_out !== 1'b0) begin failures++; $display("[TB] FAIL aclr_we got=%b exp=0", bus.Fifo_WriteEn_out); end
    checks++; if (bus.Count_out !== 3'd0) begin failures++; $display("[TB] FAIL aclr_count got=%0d exp=0", bus.Count_out); end
    checks++; if (bus.Busy_out !== 1'b1) begin failures++; $display("[TB] FAIL aclr_busy got=%b exp=1", bus.Busy_out); end
    checks++; if (bus.Fifo_Data_out !== '0) begin failures++; $display("[TB] FAIL aclr_data got=%h exp=0", bus.Fifo_Data_out); end
    do_reset();
    bus.Req_in = 4'b0001;
    @(posedge Clk);
    Clear_in = 1'b1;
    #1;
    checks++; if (bus.Fifo_WriteEn_out !== 1'b0) begin failures++; $display("[TB] FAIL aclr_edge_we got=%b exp=0", bus.Fifo_WriteEn_out); end
    checks++; if (bus.Fifo_Clear_out !== 1'b1) begin failures++; $display("[TB] FAIL aclr_edge_clear got=%b exp=1", bus.Fifo_Clear_out); end
    checks++; if (bus.Count_out !== 3'd0) begin failures++; $display("[TB] FAIL aclr_edge_count got=%0d exp=0", bus.Count_out); end
    Clear_in   = 1'b0;
    bus.Req_in = 4'b0000;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_full();
    test_flush();
    test_stall();
    test_async_clear();
    checks++; if (sb.size() != 0) begin failures++; $display("[TB] FAIL scoreboard_leftover got=%0d exp=0", sb.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
